// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences execute-stage load/store requests onto a single-port data memory
// Ports:
//   sysclk, reset_n              clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake from execute (ready only in IDLE)
//   req_write/addr/wdata/rd      request kind, byte address, store data, load destination
//   mem_addr/writeData/write     registered drive into dataMemory
//   mem_readData                 combinational read data from dataMemory
//   wb_valid/wb_ready            load result handshake toward writeback
//   wb_data/wb_rd                loaded value and its destination register
//   ld_count/st_count            saturating counts of completed loads / stores
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_W   = 3
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readData,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic [7:0]        ld_count,
    output logic [7:0]        st_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RESP, S_ST_SETUP, S_ST_WRITE, S_ST_HOLD} state_t;

    state_t            r_state, w_next;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_wb_data;
    logic [RD_W-1:0]   r_rd;
    logic [7:0]        r_ld_count, r_st_count;
    logic              w_accept;

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        wb_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = req_write ? S_ST_SETUP : S_LOAD;
            end
            S_LOAD:     w_next = S_RESP;
            S_RESP: begin
                wb_valid = 1'b1;
                if (wb_ready) w_next = S_IDLE;
            end
            S_ST_SETUP: w_next = S_ST_WRITE;
            S_ST_WRITE: w_next = S_ST_HOLD;
            S_ST_HOLD:  w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign w_accept = req_valid & req_ready;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
            r_wb_data   <= '0;
            r_ld_count  <= '0;
            r_st_count  <= '0;
        end else begin
            r_state     <= w_next;
            // registered strobe: high for the single cycle spent in ST_WRITE
            r_mem_write <= (w_next == S_ST_WRITE);
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rd    <= req_rd;
            end
            if (r_state == S_LOAD) r_wb_data <= mem_readData;
            if (r_state == S_ST_WRITE && r_st_count != 8'hFF) r_st_count <= r_st_count + 8'd1;
            if (r_state == S_RESP && wb_ready && r_ld_count != 8'hFF) r_ld_count <= r_ld_count + 8'd1;
        end
    end

    assign mem_addr      = r_addr;
    assign mem_writeData = r_wdata;
    assign mem_write     = r_mem_write;
    assign wb_data       = r_wb_data;
    assign wb_rd         = r_rd;
    assign ld_count      = r_ld_count;
    assign st_count      = r_st_count;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a behavioural memory and transaction-level model
module tb_mem_access_unit;
    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic [2:0] req_rd;
    logic [7:0] mem_addr, mem_writeData, mem_readData;
    logic       mem_write;
    logic       wb_valid, wb_ready;
    logic [7:0] wb_data;
    logic [2:0] wb_rd;
    logic [7:0] ld_count, st_count;

    mem_access_unit dut (
        .sysclk(sysclk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_addr(mem_addr), .mem_writeData(mem_writeData), .mem_write(mem_write),
        .mem_readData(mem_readData),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .ld_count(ld_count), .st_count(st_count)
    );

    always #5 sysclk = ~sysclk;

    // data memory device: synchronous write, combinational read, preset contents
    logic [7:0] mem [256];
    logic       mem_loaded = 1'b0;
    always @(posedge sysclk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 3 + 7);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_writeData;
        end
    end
    assign mem_readData = mem[mem_addr];

    // transaction-level reference: what memory should hold and how many ops completed
    logic [7:0] ref_mem [256];
    int ref_ld, ref_st;
    int n_checks, n_err;

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit [2:0] rd;
        int       waitc;
        bit [7:0] exp_data;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_write"}, int'(mem_write), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_writeData), 0);
        chk({tag, "_wb_valid"}, int'(wb_valid), 0);
        chk({tag, "_wb_data"}, int'(wb_data), 0);
        chk({tag, "_wb_rd"}, int'(wb_rd), 0);
        chk({tag, "_ld_count"}, int'(ld_count), 0);
        chk({tag, "_st_count"}, int'(st_count), 0);
    endtask

    // random traffic on the request port while the unit is busy must be ignored
    task automatic scramble();
        req_valid = 1'($urandom);
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        req_rd    = 3'($urandom);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_rd = 3'($urandom);
        chk("st_ready_T", int'(req_ready), 1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge sysclk); #1;
            if (c == 3) begin
                ref_mem[a] = d;
                if (ref_st < 255) ref_st++;
            end
            if (c < 4) begin
                chk("st_busy", int'(req_ready), 0);
                chk("st_mem_write", int'(mem_write), c == 2 ? 1 : 0);
                chk("st_addr", int'(mem_addr), int'(a));
                chk("st_wdata", int'(mem_writeData), int'(d));
                chk("st_no_wb", int'(wb_valid), 0);
                scramble();
                wb_ready = 1'($urandom);
            end else begin
                chk("st_ready_T4", int'(req_ready), 1);
                chk("st_write_T4", int'(mem_write), 0);
                chk("st_count", int'(st_count), ref_st);
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic do_load(input logic [7:0] a, input logic [2:0] rd, input int waitc, input logic [7:0] exp);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'($urandom); req_rd = rd;
        chk("ld_ready_T", int'(req_ready), 1);
        @(posedge sysclk); #1;
        chk("ld_busy_T1", int'(req_ready), 0);
        chk("ld_no_wb_T1", int'(wb_valid), 0);
        chk("ld_addr", int'(mem_addr), int'(a));
        chk("ld_no_write", int'(mem_write), 0);
        scramble();
        wb_ready = 1'($urandom);
        @(posedge sysclk); #1;
        chk("ld_wb_valid", int'(wb_valid), 1);
        chk("ld_wb_data", int'(wb_data), int'(exp));
        chk("ld_wb_rd", int'(wb_rd), int'(rd));
        chk("ld_busy_T2", int'(req_ready), 0);
        scramble();
        wb_ready = (waitc == 0);
        for (int i = 0; i < waitc; i++) begin
            @(posedge sysclk); #1;
            chk("ld_hold_valid", int'(wb_valid), 1);
            chk("ld_hold_data", int'(wb_data), int'(exp));
            chk("ld_hold_rd", int'(wb_rd), int'(rd));
            chk("ld_hold_busy", int'(req_ready), 0);
            chk("ld_hold_write", int'(mem_write), 0);
            scramble();
            wb_ready = (i == waitc - 1);
        end
        @(posedge sysclk); #1;
        if (ref_ld < 255) ref_ld++;
        chk("ld_wb_drop", int'(wb_valid), 0);
        chk("ld_ready_after", int'(req_ready), 1);
        chk("ld_count", int'(ld_count), ref_ld);
        req_valid = 1'b0;
        wb_ready  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_err = 0; ref_ld = 0; ref_st = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 3 + 7);
        tbl[0] = '{1'b1, 8'h10, 8'hA5, 3'd0, 0, 8'h00};
        tbl[1] = '{1'b0, 8'h10, 8'h00, 3'd3, 0, 8'hA5};
        tbl[2] = '{1'b0, 8'h10, 8'h00, 3'd5, 5, 8'hA5};
        tbl[3] = '{1'b1, 8'hFF, 8'h01, 3'd0, 0, 8'h00};
        tbl[4] = '{1'b0, 8'hFF, 8'h00, 3'd1, 0, 8'h01};
        tbl[5] = '{1'b0, 8'h00, 8'h00, 3'd2, 1, 8'h07};
        tbl[6] = '{1'b1, 8'h00, 8'hC3, 3'd0, 0, 8'h00};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 3'd7, 2, 8'hC3};

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_rd = '0; wb_ready = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk_reset_vals("por");
        @(negedge sysclk);
        reset_n = 1'b1;
        #1;
        chk("por_ready", int'(req_ready), 1);

        // directed table; first entry is accepted on the first edge after reset release
        foreach (tbl[k]) begin
            if (tbl[k].wr) do_store(tbl[k].addr, tbl[k].wdata);
            else do_load(tbl[k].addr, tbl[k].rd, tbl[k].waitc, tbl[k].exp_data);
        end

        // randomized mix against the reference memory
        for (int n = 0; n < 150; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_store(a, 8'($urandom));
            else do_load(a, 3'($urandom), $urandom_range(0, 3), ref_mem[a]);
        end

        // reset during ST_WRITE: strobe drops without a clock edge, write never lands
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h42; req_wdata = 8'h99;
        @(posedge sysclk); #1;
        req_valid = 1'b0;
        @(posedge sysclk); #1;
        chk("rst_st_in_write", int'(mem_write), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_st");
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset_n = 1'b1;
        ref_ld = 0; ref_st = 0;
        do_load(8'h42, 3'd6, 0, ref_mem[8'h42]);

        // reset during LOAD: pending result discarded
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_rd = 3'd4;
        @(posedge sysclk); #1;
        req_valid = 1'b0; wb_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_ld");
        @(posedge sysclk);
        @(negedge sysclk);
        reset_n = 1'b1;
        ref_ld = 0; ref_st = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sysclk); #1;
            chk("rst_ld_no_wb", int'(wb_valid), 0);
            chk("rst_ld_count", int'(ld_count), 0);
        end
        wb_ready = 1'b0;

        // 256 back-to-back stores: counter saturates, no stray write pulses
        for (int n = 0; n < 256; n++) do_store(8'($urandom), 8'($urandom));
        chk("st_saturated", int'(st_count), 255);
        do_load(tbl[0].addr, 3'd3, 0, ref_mem[tbl[0].addr]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 8: data memory address width.
REQ-002 Parameter DATA_W, default 8: data word width.
REQ-003 Parameter RD_W, default 3: destination register index width.
REQ-004 sysclk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset_n  in  1  asynchronous active-low reset; assertion SHALL take effect without a clock edge.
REQ-006 req_valid  in  1  execute stage presents a memory request.
REQ-007 req_ready  out  1  unit accepts a request this cycle.
REQ-008 req_write  in  1  1 = store (sw), 0 = load (lw).
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 req_rd  in  RD_W  load destination register.
REQ-012 mem_addr  out  ADDR_W  to dataMemory addr.
REQ-013 mem_writeData  out  DATA_W  to dataMemory writeData.
REQ-014 mem_write  out  1  to dataMemory write, level-sensitive.
REQ-015 mem_readData  in  DATA_W  from dataMemory readData, combinational.
REQ-016 wb_valid  out  1  load result available to writeback.
REQ-017 wb_ready  in  1  writeback consumes result.
REQ-018 wb_data  out  DATA_W  loaded value.
REQ-019 wb_rd  out  RD_W  destination register of loaded value.
REQ-020 ld_count, st_count  out  8 each  completed loads / stores.

Function
REQ-021 States: IDLE, LOAD, RESP, ST_SETUP, ST_WRITE, ST_HOLD; encoding free.
REQ-022 req_ready SHALL be 1 exactly when state = IDLE; request accepted on cycle with req_valid & req_ready.
REQ-023 On acceptance, req_addr, req_wdata, req_rd SHALL be captured into registers; mem_addr and mem_writeData SHALL be driven only from these registers and hold value in every state.
REQ-024 Accepted load: IDLE -> LOAD; in LOAD, mem_readData SHALL be captured into wb_data at the closing edge; LOAD -> RESP.
REQ-025 RESP: wb_valid = 1, wb_data and wb_rd stable until wb_ready = 1; on wb_valid & wb_ready, RESP -> IDLE and wb_valid = 0 the next cycle.
REQ-026 Load latency: accepted at edge T -> wb_valid high from T+2; new request acceptable on the cycle after the wb handshake.
REQ-027 Accepted store: IDLE -> ST_SETUP (mem_write = 0, addr/data stable) -> ST_WRITE (mem_write = 1 for exactly one cycle) -> ST_HOLD (mem_write = 0, addr/data stable) -> IDLE.
REQ-028 mem_write SHALL be a register output, glitch-free, 1 only in ST_WRITE.
REQ-029 Store occupancy: accepted at T, req_ready high again from T+4; stores produce no wb_valid.
REQ-030 wb_valid SHALL be 0 in every state except RESP.
REQ-031 st_count SHALL increment on ST_WRITE -> ST_HOLD; ld_count on RESP handshake; both saturate at 255 (no wrap).
REQ-032 req_valid while req_ready = 0 SHALL be ignored and SHALL NOT alter captured registers.
REQ-033 Address arithmetic: none; addresses pass through unchanged; full 0..2^ADDR_W-1 range legal.
REQ-034 Load immediately following a store to the same address SHALL return the stored value (guaranteed by ST_HOLD ordering, no forwarding logic).

Reset
REQ-035 On reset_n = 0: state = IDLE, mem_write = 0, mem_addr = 0, mem_writeData = 0, wb_valid = 0, wb_data = 0, wb_rd = 0, ld_count = 0, st_count = 0; req_ready = 1 once reset_n = 1.
REQ-036 Reset asserted mid-store SHALL drop mem_write immediately (asynchronously); reset mid-load SHALL discard the pending result with no wb_valid.
REQ-037 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-038 Store addr 0x10 data 0xA5 -> mem_write high exactly one cycle (T+2), mem_addr 0x10 / mem_writeData 0xA5 stable T+1..T+3, req_ready back at T+4, st_count = 1.
REQ-039 Then load addr 0x10 rd 3, wb_ready = 1 -> wb_valid at T+2 with wb_data 0xA5, wb_rd 3, ld_count = 1.
REQ-040 Load with wb_ready held 0 for 5 cycles -> wb_valid, wb_data, wb_rd held constant, req_ready 0 throughout; handshake on cycle 6 returns to IDLE.
REQ-041 Store addr 0xFF data 0x01 then load 0xFF and load 0x00 -> 0x01 and memory contents at 0x00 respectively; no wrap side effects.
REQ-042 reset_n pulsed low during ST_WRITE -> mem_write 0 same cycle without edge, all outputs at reset values, st_count 0.
REQ-043 256 back-to-back stores -> st_count saturates at 255; req_valid toggling while busy never causes extra mem_write pulses.
